// File: rtl/zero_extender_8in_16out_pkg.sv
// Shared definitions for the immediate-widening block: extension mode encoding.
package ext_pkg;

   typedef logic [1:0] ext_mode_t;

   localparam ext_mode_t EXT_ZERO = 2'b00;
   localparam ext_mode_t EXT_SIGN = 2'b01;
   localparam ext_mode_t EXT_HIGH = 2'b10;
   localparam ext_mode_t EXT_ONES = 2'b11;

endpackage

// File: rtl/zero_extender_8in_16out_ext_mux.sv
// Combinational mode-selected widening of an IN_W field to an OUT_W word.
module ext_mux
   import ext_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int OUT_W = 16
) (
   input  ext_mode_t        mode,
   input  logic [IN_W-1:0]  x,
   output logic [OUT_W-1:0] y
);

   // Upper bits are filled per mode; loops keep OUT_W == IN_W legal (empty fill).
   always_comb begin
      y = OUT_W'(x);
      case (mode)
         EXT_SIGN: for (int i = IN_W; i < OUT_W; i++) y[i] = x[IN_W-1];
         EXT_HIGH: y = OUT_W'(x) << (OUT_W - IN_W);
         EXT_ONES: for (int i = IN_W; i < OUT_W; i++) y[i] = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: rtl/zero_extender_8in_16out.sv
// Widens an 8-bit immediate: combinational zero-extension plus an optional
// registered, mode-selectable extension with valid flag.
module zero_extender_8in_16out
   import ext_pkg::*;
#(
   parameter int IN_W    = 8,
   parameter int OUT_W   = 16,
   parameter bit REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  bit8_in,
   input  ext_mode_t        ext_mode,
   input  logic             in_valid,
   output logic [OUT_W-1:0] bit16_out,
   output logic [OUT_W-1:0] ext_q,
   output logic             ext_valid_q
);

   logic [OUT_W-1:0] ext_d;

   assign bit16_out = OUT_W'(bit8_in);

   ext_mux #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ext_mux (
      .mode (ext_mode),
      .x    (bit8_in),
      .y    (ext_d)
   );

   generate
      if (REG_OUT) begin : g_reg
         logic [OUT_W-1:0] ext_r;
         logic [1:0]       vld_pipe;

         // Data only captured when valid, so a floating mode on idle cycles is harmless.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ext_r    <= '0;
               vld_pipe <= '0;
            end else begin
               vld_pipe <= {vld_pipe[0], in_valid};
               if (in_valid) ext_r <= ext_d;
            end
         end

         assign ext_q       = ext_r;
         assign ext_valid_q = vld_pipe[0];
      end else begin : g_comb
         assign ext_q       = ext_d;
         assign ext_valid_q = in_valid;
      end
   endgenerate

endmodule

// File: tb/tb_zero_extender_8in_16out.sv
// Self-checking bench: directed vector table, reset corners, exhaustive zero-extend
// sweep and randomized traffic against an arithmetic reference model.
module tb_zero_extender_8in_16out;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  bit8_in;
   logic [1:0]  ext_mode;
   logic        in_valid;
   logic [15:0] bit16_out;
   logic [15:0] ext_q;
   logic        ext_valid_q;

   int n_chk  = 0;
   int n_pass = 0;

   zero_extender_8in_16out dut (
      .clk         (clk),
      .rst         (rst),
      .bit8_in     (bit8_in),
      .ext_mode    (ext_mode),
      .in_valid    (in_valid),
      .bit16_out   (bit16_out),
      .ext_q       (ext_q),
      .ext_valid_q (ext_valid_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  x;
      logic [1:0]  mode;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference extension computed arithmetically from the mode rules.
   function automatic logic [15:0] ref_f(input logic [1:0] mode, input logic [7:0] x);
      int v;
      v = int'(x);
      case (mode)
         2'd0:    return 16'(v);
         2'd1:    return (v >= 128) ? 16'(v + 65280) : 16'(v);
         2'd2:    return 16'(v * 256);
         default: return 16'(65280 + v);
      endcase
   endfunction

   logic [15:0] m_q;
   logic        m_v;

   initial begin
      tbl[0] = '{8'h80, 2'd0, 16'h0080};
      tbl[1] = '{8'h80, 2'd1, 16'hFF80};
      tbl[2] = '{8'h80, 2'd2, 16'h8000};
      tbl[3] = '{8'h80, 2'd3, 16'hFF80};
      tbl[4] = '{8'hFF, 2'd1, 16'hFFFF};
      tbl[5] = '{8'hFF, 2'd0, 16'h00FF};
      tbl[6] = '{8'h00, 2'd3, 16'hFF00};
      tbl[7] = '{8'h05, 2'd0, 16'h0005};
      tbl[8] = '{8'h1B, 2'd2, 16'h1B00};
      tbl[9] = '{8'h7F, 2'd1, 16'h007F};

      // Reset state; combinational path live during reset
      rst = 1'b1; bit8_in = 8'h00; ext_mode = 2'd0; in_valid = 1'b0;
      #5;
      chk("rst_bit16_00", bit16_out, 16'h0000);
      chk("rst_ext_q", ext_q, 16'h0000);
      chk("rst_valid", {15'd0, ext_valid_q}, 16'd0);
      bit8_in = 8'h03;
      #5;
      chk("rst_bit16_03", bit16_out, 16'h0003);
      @(posedge clk); #1;
      chk("rst_ext_q_held", ext_q, 16'h0000);
      rst = 1'b0;

      // Directed table, one result per edge
      foreach (tbl[i]) begin
         bit8_in = tbl[i].x; ext_mode = tbl[i].mode; in_valid = 1'b1;
         #1;
         chk("tbl_bit16", bit16_out, {8'h00, tbl[i].x});
         @(posedge clk); #1;
         chk("tbl_ext_q", ext_q, tbl[i].exp);
         chk("tbl_valid", {15'd0, ext_valid_q}, 16'd1);
      end

      // Idle cycle with unknown mode must hold 007F
      in_valid = 1'b0; bit8_in = 8'hAA; ext_mode = 2'bxx;
      @(posedge clk); #1;
      chk("hold_ext_q", ext_q, 16'h007F);
      chk("hold_valid", {15'd0, ext_valid_q}, 16'd0);
      chk("hold_bit16", bit16_out, 16'h00AA);

      // Async reset mid-stream
      in_valid = 1'b1; bit8_in = 8'h80; ext_mode = 2'd1;
      @(posedge clk); #1;
      chk("pre_rst_ext_q", ext_q, 16'hFF80);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_ext_q", ext_q, 16'h0000);
      chk("async_rst_valid", {15'd0, ext_valid_q}, 16'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b1; bit8_in = 8'h00; ext_mode = 2'd3;
      @(posedge clk); #1;
      chk("post_rst_ext_q", ext_q, 16'hFF00);
      chk("post_rst_valid", {15'd0, ext_valid_q}, 16'd1);
      in_valid = 1'b0;

      // Exhaustive zero-extend sweep
      for (int v = 0; v < 256; v++) begin
         bit8_in = 8'(v);
         #1;
         chk("sweep_bit16", bit16_out, 16'(v));
      end

      // Randomized traffic vs reference model
      @(posedge clk); #1;
      m_q = ext_q; m_v = ext_valid_q;
      chk("rand_start_v", {15'd0, ext_valid_q}, 16'd0);
      for (int n = 0; n < 300; n++) begin
         in_valid = 1'($urandom_range(0, 1));
         ext_mode = 2'($urandom_range(0, 3));
         bit8_in  = 8'($urandom_range(0, 255));
         #1;
         chk("rand_bit16", bit16_out, {8'h00, bit8_in});
         m_v = in_valid;
         if (in_valid) m_q = ref_f(ext_mode, bit8_in);
         @(posedge clk); #1;
         chk("rand_ext_q", ext_q, m_q);
         chk("rand_valid", {15'd0, ext_valid_q}, {15'd0, m_v});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/zero_extender_8in_16out.md
Name: zero_extender_8in_16out

Overview:
- Immediate-widening block in the processor datapath; widens an 8-bit immediate/byte field to a 16-bit datapath word.
- Provides a purely combinational zero-extended output, `bit16_out`, which is the primary contract.
- Also provides a registered, mode-selectable extension result (`ext_q`) with a valid flag, for pipelined consumers in the decode/execute stage.

Parameters:
- IN_W, 8, input field width.
- OUT_W, 16, output word width; must be ≥ IN_W.
- REG_OUT, 1, 1 = `ext_q`/`ext_valid_q` registered; 0 = `ext_q` driven combinationally and `ext_valid_q` = `in_valid`.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- bit8_in  input  IN_W  input field.
- ext_mode  input  2  extension mode for `ext_q`: 00 zero, 01 sign, 10 high-place, 11 ones-fill.
- in_valid  input  1  qualifies `bit8_in`/`ext_mode` for the registered path.
- bit16_out  output  OUT_W  combinational zero extension of `bit8_in`.
- ext_q  output  OUT_W  registered mode-selected extension.
- ext_valid_q  output  1  `ext_q` holds a valid result.

Behaviour:

`bit16_out` (combinational, 0-cycle latency):
- `bit16_out[IN_W-1:0]` = `bit8_in`.
- `bit16_out[OUT_W-1:IN_W]` = 0.
- Independent of `clk`, `rst`, `ext_mode` and `in_valid`; valid while `rst` is asserted.

Extension function `f(mode, x)`:
- 00: zero-extend, identical to `bit16_out`.
- 01: sign-extend; upper bits replicate `x[IN_W-1]`.
- 10: high-place; `x` occupies `[OUT_W-1:OUT_W-IN_W]`, lower bits 0. For OUT_W=16 this is `{x, 8'h00}`.
- 11: ones-fill; upper bits all 1, lower bits = `x`.

Registered path (REG_OUT=1):
- On `rst` high, asynchronously: `ext_q` = 0, `ext_valid_q` = 0.
- At each rising edge with `rst` low:
  - `ext_valid_q` <= `in_valid`.
  - If `in_valid` = 1: `ext_q` <= `f(ext_mode, bit8_in)`.
  - If `in_valid` = 0: `ext_q` holds its previous value.
- Latency is 1 cycle; a new input can be accepted every cycle, with no backpressure.

Boundary and corner cases:
- `bit8_in` = 8'hFF: `bit16_out` = 16'h00FF; mode 01 gives 16'hFFFF.
- `bit8_in` = 8'h80: mode 01 gives 16'hFF80; mode 00 gives 16'h0080.
- `bit8_in` = 0: mode 11 gives 16'hFF00.
- Reset asserted mid-stream clears `ext_q`/`ext_valid_q` immediately. The first valid result after reset release appears one edge after `in_valid` is sampled high.
- X/Z on `ext_mode` while `in_valid` = 0 must not affect `ext_q`.

Decomposition:
- Shared package `ext_pkg`:
  - mode constants EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_HIGH=2'b10, EXT_ONES=2'b11.
  - typedef for the 2-bit mode.
- One combinational sub-module, `ext_mux`, parameterised by IN_W/OUT_W, implements `f(mode, x)`.
- The top level holds `bit16_out` assignment, the mode mux instance, and the async-reset output register.

Test Plan:
1. `rst` pulsed high, `bit8_in` = 8'h00, then `bit8_in` = 8'h03 → after 5 ns `bit16_out` = 16'h0003, including while `rst` is high; `ext_q` = 0 and `ext_valid_q` = 0 during reset.
2. `bit8_in` sequence 8'h05, 8'h1B, 8'hFF applied 105 ns apart → `bit16_out` = 16'h0005, 16'h001B, 16'h00FF, each correct within 5 ns.
3. `in_valid` = 1 with `bit8_in` = 8'h80 for modes 00/01/10/11 on consecutive edges → `ext_q` = 16'h0080, 16'hFF80, 16'h8000, 16'hFF80 one cycle later each; `ext_valid_q` = 1.
4. `in_valid` = 1 with 8'h7F mode 01, then `in_valid` = 0 with 8'hAA → `ext_q` stays 16'h007F; `ext_valid_q` goes 1 then 0.
5. `rst` asserted asynchronously between edges while `ext_q` = 16'hFF80 → `ext_q` = 0 and `ext_valid_q` = 0 immediately. After release, `in_valid` = 1 with 8'h00 mode 11 gives `ext_q` = 16'hFF00 after one edge.
6. Exhaustive sweep of `bit8_in` 0..255 → `bit16_out` == {8'h00, `bit8_in`} for every value.
